// File: rtl/full_handshake_rx_pkg.sv
// Shared definitions for the four-phase handshake receiver.
//  - rx_state_e      : one-hot RX FSM encoding (IDLE=2'b01, ACK=2'b10)
//  - MIN_SYNC_STAGES : smallest synchroniser depth, shared with the TX end
`timescale 1ns/1ps
package full_handshake_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_ACK  = 2'b10
  } rx_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/full_handshake_rx_cdc_sync_bit.sv
// cdc_sync_bit: single-bit flop chain bringing an asynchronous level into clk.
//  clk  in  RX-domain clock
//  rst  in  asynchronous active-high reset, chain cleared to 0
//  d    in  asynchronous input level
//  q    out d after SYNC_STAGES flops
`timescale 1ns/1ps
module cdc_sync_bit
  import full_handshake_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous level through the chain; stage 0 may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/full_handshake_rx.sv
// full_handshake_rx: receiver end of a four-phase req/ack CDC handshake.
// Captures the TX word into a one-word buffer and presents it on valid/ready.
//  clk           in   RX-domain clock
//  rst           in   asynchronous active-high reset
//  req_i         in   request from TX domain (asynchronous)
//  req_data_i    in   TX data, stable while req_i=1
//  ack_o         out  acknowledge to TX, straight from a flop
//  data_valid_o  out  data_o holds an unconsumed word
//  data_o        out  received word
//  data_ready_i  in   consumer accepts data_o when data_valid_o=1
//  busy_o        out  handshake in progress (state != IDLE)
//  xfer_cnt_o    out  captured-word counter, wraps silently
`timescale 1ns/1ps
module full_handshake_rx
  import full_handshake_rx_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [DW-1:0]    req_data_i,
  output logic             ack_o,
  output logic             data_valid_o,
  output logic [DW-1:0]    data_o,
  input  logic             data_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  logic      req_s;
  logic      can_take_c;
  rx_state_e state;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_i),
    .q  (req_s)
  );

  // A drain and a capture may share one edge, so a full buffer being read counts as free.
  assign can_take_c = !data_valid_o || data_ready_i;

  // Handshake FSM, output buffer and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ack_o        <= 1'b0;
      busy_o       <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      xfer_cnt_o   <= '0;
    end else begin
      // Drain first; a capture in the same cycle below re-asserts valid.
      if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_s && can_take_c) begin
            data_o       <= req_data_i;
            data_valid_o <= 1'b1;
            ack_o        <= 1'b1;
            busy_o       <= 1'b1;
            xfer_cnt_o   <= xfer_cnt_o + CNT_W'(1);
            state        <= ST_ACK;
          end else begin
            // Either no request or stalled on a full buffer: TX keeps holding req.
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
          end
        end

        ST_ACK: begin
          if (!req_s) begin
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            ack_o  <= 1'b1;
            busy_o <= 1'b1;
          end
        end

        default: begin
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
